// File: rtl/mp3_pkg.sv
// mp3_pkg: shared definitions for the MP3 command scheduler.
//   - state_t   : scheduler FSM encoding (IDLE, REQ, WAIT_FRAME)
//   - CMD_*     : bit index of each user command in the pending/event vectors
//   - *_DEF     : default widths for track index and volume
package mp3_pkg;

  localparam int TRACK_W_DEF = 3;
  localparam int VOL_W_DEF   = 4;

  localparam int CMD_NEXT = 0;
  localparam int CMD_PRE  = 1;
  localparam int CMD_VOLP = 2;
  localparam int CMD_VOLD = 3;
  localparam int NUM_CMDS = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQ        = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

endpackage

// File: rtl/mp3_cmd_scheduler_btn_debounce.sv
// btn_debounce: synchroniser, debounce filter and rising-edge event for one
// raw push button.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_raw        : raw asynchronous button level (active-high)
//   o_event      : one-cycle pulse on each accepted press
// Event latency from a raw rising edge: 2 (sync) + DEB_CYCLES (filter) + 1.
// Optional macro MP3_CMD_REPEAT_EN adds REPEAT_EN/REPEAT_CYCLES: while the
// filtered level stays high, the event is regenerated every REPEAT_CYCLES.
module btn_debounce #(
  parameter int DEB_CYCLES    = 1000000
`ifdef MP3_CMD_REPEAT_EN
  , parameter bit REPEAT_EN     = 1'b0
  , parameter int REPEAT_CYCLES = 25000000
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_event
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  // cnt counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= i_raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = level & ~level_q;

`ifdef MP3_CMD_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;

  // The period restarts on the first event and on every repeat.
  assign rep_fire = REPEAT_EN & level & ~rise & (rep_cnt == REP_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rep_cnt <= '0;
    end else if (!level || rise || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  assign o_event = rise | rep_fire;
`else
  assign o_event = rise;
`endif

endmodule

// File: rtl/mp3_cmd_scheduler.sv
// mp3_cmd_scheduler: debounces the player buttons, keeps them as pending
// commands, runs one track-load handshake at a time with the decoder, and
// commits the visible track/volume only on a frame-start pulse.
//   i_clk, i_rst                 : 100 MHz clock, async active-high reset
//   i_next, i_pre                : raw track buttons
//   i_vol_plus, i_vol_dec        : raw volume buttons
//   i_frame                      : one-cycle frame-start pulse
//   o_load_req, o_load_track     : load request / requested track to decoder
//   i_load_ack                   : one-cycle decoder acceptance
//   o_track, o_volume            : committed track index and volume
//   o_busy                       : FSM outside IDLE
//   o_err                        : one-cycle pulse on load-request timeout
//   o_state                      : FSM state, for observation
// Handshake: o_load_req rises with o_load_track valid and both hold until a
// one-cycle i_load_ack (accepted only in REQ) or the timeout; dropping
// o_load_req without an ack (timeout or reset) cancels the request.
// Optional macro MP3_CMD_REPEAT_EN: auto-repeat for the volume buttons.
module mp3_cmd_scheduler
  import mp3_pkg::*;
#(
  parameter int NUM_TRACKS    = 8,
  parameter int TRACK_W       = TRACK_W_DEF,
  parameter int VOL_W         = VOL_W_DEF,
  parameter int VOL_MAX       = 15,
  parameter int VOL_STEP      = 1,
  parameter int DEB_CYCLES    = 1000000,
  parameter int ACK_TIMEOUT   = 65535,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_next,
  input  logic               i_pre,
  input  logic               i_vol_plus,
  input  logic               i_vol_dec,
  input  logic               i_frame,
  output logic               o_load_req,
  output logic [TRACK_W-1:0] o_load_track,
  input  logic               i_load_ack,
  output logic [TRACK_W-1:0] o_track,
  output logic [VOL_W-1:0]   o_volume,
  output logic               o_busy,
  output logic               o_err,
  output state_t             o_state
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [VOL_W:0]     MAX_EXT    = (VOL_W + 1)'(VOL_MAX);
  localparam logic [VOL_W:0]     STEP_EXT   = (VOL_W + 1)'(VOL_STEP);
  localparam logic [VOL_W-1:0]   VOL_RST    = VOL_W'(VOL_MAX / 2);

  logic [NUM_CMDS-1:0] raw;
  logic [NUM_CMDS-1:0] evt;

  assign raw[CMD_NEXT] = i_next;
  assign raw[CMD_PRE]  = i_pre;
  assign raw[CMD_VOLP] = i_vol_plus;
  assign raw[CMD_VOLD] = i_vol_dec;

  for (genvar g = 0; g < NUM_CMDS; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
`ifdef MP3_CMD_REPEAT_EN
      , .REPEAT_EN((g == CMD_VOLP) || (g == CMD_VOLD))
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (raw[g]),
      .o_event(evt[g])
    );
  end

  state_t              state, state_n;
  logic [NUM_CMDS-1:0] pend, pend_n, clr;
  logic [VOL_W-1:0]    staged_vol, staged_n, volume_n;
  logic [TMO_W-1:0]    tmo_cnt, tmo_n;
  logic                load_req_n, err_n;
  logic [TRACK_W-1:0]  load_track_n, track_n, track_inc, track_dec;
  logic [VOL_W:0]      vol_ext, vol_up, vol_dn;

  // One extra bit so the increment cannot wrap before saturation.
  assign vol_ext = {1'b0, staged_vol};
  assign vol_up  = ((vol_ext + STEP_EXT) > MAX_EXT) ? MAX_EXT : (vol_ext + STEP_EXT);
  assign vol_dn  = (vol_ext < STEP_EXT) ? '0 : (vol_ext - STEP_EXT);

  assign track_inc = (o_track == LAST_TRACK) ? '0 : (o_track + TRACK_W'(1));
  assign track_dec = (o_track == '0) ? LAST_TRACK : (o_track - TRACK_W'(1));

  always_comb begin
    state_n      = state;
    load_req_n   = o_load_req;
    load_track_n = o_load_track;
    track_n      = o_track;
    staged_n     = staged_vol;
    tmo_n        = tmo_cnt;
    err_n        = 1'b0;
    clr          = '0;
    case (state)
      IDLE: begin
        tmo_n = '0;
        // Opposing presses cancel each other.
        if (pend[CMD_VOLP] && pend[CMD_VOLD]) begin
          clr[CMD_VOLP] = 1'b1;
          clr[CMD_VOLD] = 1'b1;
        end else if (pend[CMD_VOLP]) begin
          staged_n      = vol_up[VOL_W-1:0];
          clr[CMD_VOLP] = 1'b1;
        end else if (pend[CMD_VOLD]) begin
          staged_n      = vol_dn[VOL_W-1:0];
          clr[CMD_VOLD] = 1'b1;
        end
        if (pend[CMD_NEXT] && pend[CMD_PRE]) begin
          clr[CMD_NEXT] = 1'b1;
          clr[CMD_PRE]  = 1'b1;
        end else if (pend[CMD_NEXT] || pend[CMD_PRE]) begin
          load_track_n  = pend[CMD_NEXT] ? track_inc : track_dec;
          load_req_n    = 1'b1;
          clr[CMD_NEXT] = 1'b1;
          clr[CMD_PRE]  = 1'b1;
          state_n       = REQ;
        end
      end
      REQ: begin
        if (i_load_ack) begin
          load_req_n = 1'b0;
          state_n    = WAIT_FRAME;
        end else if (tmo_cnt == TMO_LAST) begin
          load_req_n = 1'b0;
          err_n      = 1'b1;
          state_n    = IDLE;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      WAIT_FRAME: begin
        if (i_frame) begin
          track_n = o_load_track;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A new event wins over a clear in the same cycle, so it is never lost.
    pend_n   = (pend & ~clr) | evt;
    volume_n = i_frame ? staged_vol : o_volume;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      pend         <= '0;
      o_load_req   <= 1'b0;
      o_load_track <= '0;
      o_track      <= '0;
      o_volume     <= VOL_RST;
      staged_vol   <= VOL_RST;
      tmo_cnt      <= '0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      o_load_req   <= load_req_n;
      o_load_track <= load_track_n;
      o_track      <= track_n;
      o_volume     <= volume_n;
      staged_vol   <= staged_n;
      tmo_cnt      <= tmo_n;
      o_err        <= err_n;
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_mp3_cmd_scheduler.sv
module tb_mp3_cmd_scheduler;
  import mp3_pkg::*;

  localparam int NT   = 4;
  localparam int TW   = 3;
  localparam int VW   = 4;
  localparam int VMAX = 15;
  localparam int DEB  = 4;
  localparam int TMO  = 16;
  localparam int REP  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    btn = '0;
  logic          frame = 1'b0;
  logic          ack = 1'b0;
  logic          load_req;
  logic [TW-1:0] load_track;
  logic [TW-1:0] track;
  logic [VW-1:0] volume;
  logic          busy;
  logic          err;
  state_t        st;

  mp3_cmd_scheduler #(
    .NUM_TRACKS(NT), .TRACK_W(TW), .VOL_W(VW), .VOL_MAX(VMAX), .VOL_STEP(1),
    .DEB_CYCLES(DEB), .ACK_TIMEOUT(TMO), .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_next(btn[CMD_NEXT]), .i_pre(btn[CMD_PRE]),
    .i_vol_plus(btn[CMD_VOLP]), .i_vol_dec(btn[CMD_VOLD]),
    .i_frame(frame),
    .o_load_req(load_req), .o_load_track(load_track), .i_load_ack(ack),
    .o_track(track), .o_volume(volume), .o_busy(busy), .o_err(err),
    .o_state(st)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Track index and volume as the user would see them, from the rules alone.
  logic [TW-1:0] m_track;
  logic [VW-1:0] m_staged;
  logic [VW-1:0] m_vol;

  function automatic logic [TW-1:0] model_next_track(input logic [TW-1:0] t, input bit fwd);
    int v;
    v = fwd ? (int'(t) + 1) % NT : (int'(t) + NT - 1) % NT;
    return TW'(v);
  endfunction

  function automatic logic [VW-1:0] model_vol(input logic [VW-1:0] v, input int delta);
    int r;
    r = int'(v) + delta;
    if (r > VMAX) r = VMAX;
    if (r < 0) r = 0;
    return VW'(r);
  endfunction

  task automatic model_reset();
    m_track  = '0;
    m_staged = VW'(VMAX / 2);
    m_vol    = VW'(VMAX / 2);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
    m_vol = m_staged;
  endtask

  task automatic apply_reset();
    btn = '0; ack = 1'b0; frame = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(2);
  endtask

  // Waits for a load request, checks it, acks after ack_delay cycles and
  // commits with a frame; optionally puts a frame in the ack cycle too.
  task automatic handshake(input logic [TW-1:0] exp_track, input int ack_delay,
                           input bit frame_with_ack, input int frame_delay);
    int waited = 0;
    while (load_req !== 1'b1 && waited < 40) begin
      tick(1);
      waited++;
    end
    checks++;
    if (load_req !== 1'b1) begin
      failures++;
      $display("FAIL hs_req_seen got=%b exp=1 after %0d cycles", load_req, waited);
      return;
    end
    checks++;
    if (load_track !== exp_track) begin
      failures++;
      $display("FAIL hs_load_track got=%0d exp=%0d", load_track, exp_track);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hs_busy_req got=%b exp=1", busy);
    end
    for (int i = 0; i < ack_delay; i++) begin
      tick(1);
      checks++;
      if (load_req !== 1'b1 || load_track !== exp_track) begin
        failures++;
        $display("FAIL hs_hold req=%b track=%0d exp req=1 track=%0d", load_req, load_track, exp_track);
      end
    end
    ack = 1'b1;
    if (frame_with_ack) frame = 1'b1;
    tick(1);
    ack = 1'b0;
    if (frame_with_ack) begin
      frame = 1'b0;
      m_vol = m_staged;
    end
    checks++;
    if (load_req !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hs_after_ack req=%b busy=%b exp req=0 busy=1", load_req, busy);
    end
    tick(frame_delay);
    checks++;
    if (track !== m_track) begin
      failures++;
      $display("FAIL hs_track_before_frame got=%0d exp=%0d", track, m_track);
    end
    pulse_frame();
    m_track = exp_track;
    checks++;
    if (track !== m_track || busy !== 1'b0) begin
      failures++;
      $display("FAIL hs_commit track=%0d busy=%b exp track=%0d busy=0", track, busy, m_track);
    end
    checks++;
    if (volume !== m_vol) begin
      failures++;
      $display("FAIL hs_volume got=%0d exp=%0d", volume, m_vol);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    btn = '0; rst = 1'b1;
    tick(2);
    model_reset();
    checks++;
    if (load_req !== 1'b0 || load_track !== '0 || track !== '0 || busy !== 1'b0 ||
        err !== 1'b0 || st !== IDLE) begin
      failures++;
      $display("FAIL reset_outputs req=%b ltrack=%0d track=%0d busy=%b err=%b st=%0d exp all 0",
               load_req, load_track, track, busy, err, st);
    end
    checks++;
    if (volume !== VW'(7)) begin
      failures++;
      $display("FAIL reset_volume got=%0d exp=7", volume);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_first_load();
    apply_reset();
    press(CMD_NEXT, 10);
    handshake(TW'(1), 3, 1'b0, 2);
    tick(8);
  endtask

  task automatic test_pre_wrap();
    apply_reset();
    press(CMD_PRE, 6);
    handshake(TW'(3), 1, 1'b0, 1);
    tick(8);
  endtask

  task automatic test_volume();
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      int b;
      b = (i < 12) ? CMD_VOLP : CMD_VOLD;
      press(b, 6);
      tick(8);
      m_staged = model_vol(m_staged, (b == CMD_VOLP) ? 1 : -1);
      checks++;
      if (volume !== m_vol) begin
        failures++;
        $display("FAIL vol_before_frame step=%0d got=%0d exp=%0d", i, volume, m_vol);
      end
      pulse_frame();
      checks++;
      if (volume !== m_vol) begin
        failures++;
        $display("FAIL vol_commit step=%0d got=%0d exp=%0d", i, volume, m_vol);
      end
    end
    checks++;
    if (volume !== VW'(13)) begin
      failures++;
      $display("FAIL vol_final got=%0d exp=13", volume);
    end
  endtask

  task automatic test_random_volume();
    for (int i = 0; i < 10; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        btn[CMD_VOLP] = 1'b1; btn[CMD_VOLD] = 1'b1;
        tick(6);
        btn[CMD_VOLP] = 1'b0; btn[CMD_VOLD] = 1'b0;
      end else begin
        press((kind <= 2) ? CMD_VOLP : CMD_VOLD, $urandom_range(6, 9));
        m_staged = model_vol(m_staged, (kind <= 2) ? 1 : -1);
      end
      tick(8);
      pulse_frame();
      checks++;
      if (volume !== m_vol) begin
        failures++;
        $display("FAIL vol_random kind=%0d got=%0d exp=%0d", kind, volume, m_vol);
      end
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int err_cnt = 0;
    btn[CMD_NEXT] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 6) btn[CMD_NEXT] = 1'b0;
      if (load_req === 1'b1) req_cycles++;
      if (err === 1'b1) err_cnt++;
    end
    checks++;
    if (req_cycles != TMO) begin
      failures++;
      $display("FAIL timeout_req_cycles got=%0d exp=%0d", req_cycles, TMO);
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL timeout_err_pulses got=%0d exp=1", err_cnt);
    end
    checks++;
    if (track !== m_track || busy !== 1'b0 || st !== IDLE || load_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state track=%0d busy=%b st=%0d req=%b exp track=%0d idle",
               track, busy, st, load_req, m_track);
    end
  endtask

  task automatic test_simultaneous();
    int req_seen = 0;
    btn[CMD_NEXT] = 1'b1; btn[CMD_PRE] = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      if (i == 6) begin
        btn[CMD_NEXT] = 1'b0; btn[CMD_PRE] = 1'b0;
      end
      if (load_req === 1'b1 || busy === 1'b1) req_seen++;
    end
    checks++;
    if (req_seen != 0 || track !== m_track) begin
      failures++;
      $display("FAIL simultaneous_cancel busy_cycles=%0d track=%0d exp 0 and %0d", req_seen, track, m_track);
    end
  endtask

  task automatic test_next_during_req();
    logic [TW-1:0] exp1;
    logic [TW-1:0] exp2;
    exp1 = model_next_track(m_track, 1'b1);
    exp2 = model_next_track(exp1, 1'b1);
    press(CMD_NEXT, 6);
    tick(6);
    press(CMD_NEXT, 6);
    handshake(exp1, 0, 1'b0, 1);
    handshake(exp2, $urandom_range(0, 4), 1'b0, $urandom_range(0, 3));
    tick(8);
  endtask

  task automatic test_ack_ignored();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(2);
    checks++;
    if (busy !== 1'b0 || load_req !== 1'b0 || track !== m_track) begin
      failures++;
      $display("FAIL ack_in_idle busy=%b req=%b track=%0d exp 0 0 %0d", busy, load_req, track, m_track);
    end
  endtask

  task automatic test_random_tracks();
    for (int i = 0; i < 8; i++) begin
      bit fwd;
      fwd = 1'($urandom_range(0, 1));
      press(fwd ? CMD_NEXT : CMD_PRE, $urandom_range(6, 8));
      handshake(model_next_track(m_track, fwd), $urandom_range(0, 5),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
      tick(8);
    end
  endtask

  task automatic test_reset_mid_req();
    int waited = 0;
    press(CMD_NEXT, 6);
    while (load_req !== 1'b1 && waited < 20) begin
      tick(1);
      waited++;
    end
    checks++;
    if (load_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_req_seen got=%b exp=1", load_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (load_req !== 1'b0 || busy !== 1'b0 || track !== '0 || volume !== VW'(7) || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_req req=%b busy=%b track=%0d vol=%0d err=%b exp 0 0 0 7 0",
               load_req, busy, track, volume, err);
    end
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(20);
    checks++;
    if (busy !== 1'b0 || load_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_clears_pending busy=%b req=%b exp 0 0", busy, load_req);
    end
  endtask

`ifdef MP3_CMD_REPEAT_EN
  // Raw level held 36 cycles: the filtered level stays high long enough for
  // the first event plus four repeats at an 8-cycle period.
  task automatic test_repeat();
    press(CMD_VOLD, 36);
    tick(10);
    m_staged = model_vol(m_staged, -5);
    pulse_frame();
    checks++;
    if (volume !== m_vol) begin
      failures++;
      $display("FAIL repeat_vol_dec got=%0d exp=%0d", volume, m_vol);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_first_load();
    test_pre_wrap();
    test_volume();
    test_random_volume();
    test_timeout();
    test_simultaneous();
    test_next_during_req();
    test_ack_ignored();
    test_random_tracks();
`ifdef MP3_CMD_REPEAT_EN
    test_repeat();
`endif
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
